dmem_arbiter: RTL

Two-port arbiter and access sequencer for the 64-bit data memory (Memoria64) in the multicycle RISC-V core. Port 0 is the core's load/store path, driven by the control unit and the ALU_OUT/REG_B registers. Port 1 is the program loader / debug port. The block latches one request at a time, drives the memory address, data and write strobe for exactly one access, waits the configured memory latency, then returns read data with a single-cycle acknowledge.

---
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and access sequencer for the 64-bit data memory
// Optional macro DMEM_ARB_RR_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WR0,
  input  logic        WR1,
  input  logic [63:0] ADDR0,
  input  logic [63:0] ADDR1,
  input  logic [63:0] WDATA0,
  input  logic [63:0] WDATA1,
  output logic        ACK0,
  output logic        ACK1,
  output logic [63:0] RDATA0,
  output logic [63:0] RDATA1,
  output logic [63:0] MEM_ADDR,
  output logic [63:0] MEM_WDATA,
  output logic        MEM_WR,
  input  logic [63:0] MEM_RDATA,
  output logic        BUSY,
  output logic        GRANT_ID
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_t      state;
  state_t      state_nx;
  logic        any_req;
  logic        win;
  logic        lat_wr;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [3:0]  cnt;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;

  // Pointer holds the last granted port; the other port wins a tie.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rr_ptr <= 1'b1;
    end else if (state == S_IDLE && any_req) begin
      rr_ptr <= win;
    end
  end

  always_comb begin
    win = (REQ0 && REQ1) ? ~rr_ptr : REQ1;
  end
`else
  always_comb begin
    win = ~REQ0;
  end
`endif

  assign any_req = REQ0 | REQ1;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (any_req) state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_WAIT;
      S_WAIT:   if (cnt == 4'd1) state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= S_IDLE;
      BUSY      <= 1'b0;
      GRANT_ID  <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= 64'd0;
      lat_wdata <= 64'd0;
      cnt       <= 4'd0;
      RDATA0    <= 64'd0;
      RDATA1    <= 64'd0;
    end else begin
      state <= state_nx;
      BUSY  <= (state_nx != S_IDLE);
      case (state)
        S_IDLE: begin
          if (any_req) begin
            GRANT_ID  <= win;
            lat_wr    <= win ? WR1 : WR0;
            lat_addr  <= win ? ADDR1 : ADDR0;
            lat_wdata <= win ? WDATA1 : WDATA0;
            cnt       <= LAT_INIT;
          end
        end
        S_WAIT: begin
          // Writes run the same sequence but never disturb the read-data registers.
          if (cnt == 4'd1) begin
            if (!lat_wr) begin
              if (GRANT_ID) RDATA1 <= MEM_RDATA;
              else          RDATA0 <= MEM_RDATA;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign MEM_ADDR  = lat_addr;
  assign MEM_WDATA = lat_wdata;
  assign MEM_WR    = (state == S_ACCESS) && lat_wr;
  assign ACK0      = (state == S_RESP) && !GRANT_ID;
  assign ACK1      = (state == S_RESP) && GRANT_ID;

endmodule
